// File: rtl/eq_gain_loader_if.sv
// Gain-word stream handshake between the configuration source and eq_gain_loader.
// One word per cycle when cfg_valid and cfg_ready are both high.
interface eq_gain_loader_if #(
    parameter int GW = 16
) ();
    logic          cfg_valid;
    logic          cfg_ready;
    logic [GW-1:0] cfg_data;
    logic          cfg_last;

    modport master (
        output cfg_valid,
        output cfg_data,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/eq_gain_loader.sv
// Collects one frame of clamped band gains into a shadow bank and commits the whole
// set to the active bank on a sample strobe, so the equalizer never sees a mixed set.
//
// state | meaning
// IDLE  | waiting for band 0 of a new frame
// LOAD  | collecting bands 1..NBANDS-1 into the shadow bank
// DRAIN | frame was too long; swallowing words until cfg_last
// PEND  | full frame held in shadow, waiting for sample_strobe to commit
module eq_gain_loader #(
    parameter int            NBANDS       = 8,
    parameter int            GW           = 16,
    parameter logic [GW-1:0] DEFAULT_GAIN = 16'h4000,
    parameter logic [GW-1:0] GMAX         = 16'h7FFF
) (
    input  logic                         clk,
    input  logic                         rst,
    eq_gain_loader_if.slave              cfg,
    input  logic                         sample_strobe_i,
    input  logic                         err_clr_i,
    output logic [NBANDS-1:0][GW-1:0]    g_o,
    output logic                         busy_o,
    output logic                         commit_done_o,
    output logic                         err_o
);
    localparam int            IW       = $clog2(NBANDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBANDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        PEND  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [NBANDS-1:0][GW-1:0]   shadow_q, shadow_d;
    logic [NBANDS-1:0][GW-1:0]   g_q, g_d;
    logic                        err_q, err_d;
    logic                        commit_done_q, commit_done_d;

    logic                        accept;
    logic                        err_set;
    logic [GW-1:0]               word_clamped;

    // Ready must drop during reset even though the state register is not yet IDLE-reset.
    assign cfg.cfg_ready = !rst && (state_q != PEND);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign word_clamped  = (cfg.cfg_data > GMAX) ? GMAX : cfg.cfg_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            shadow_q      <= {NBANDS{DEFAULT_GAIN}};
            g_q           <= {NBANDS{DEFAULT_GAIN}};
            err_q         <= 1'b0;
            commit_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            g_q           <= g_d;
            err_q         <= err_d;
            commit_done_q <= commit_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        g_d           = g_q;
        commit_done_d = 1'b0;
        err_set       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shadow_d[0] = word_clamped;
                    if (cfg.cfg_last) begin
                        err_set = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d   = IW'(1);
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    shadow_d[idx_q] = word_clamped;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (cfg.cfg_last) begin
                            state_d = PEND;
                        end else begin
                            err_set = 1'b1;
                            state_d = DRAIN;
                        end
                    end else if (cfg.cfg_last) begin
                        err_set = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DRAIN: begin
                if (accept && cfg.cfg_last) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            PEND: begin
                // Strobes that coincide with the final word land in LOAD and are ignored.
                if (sample_strobe_i) begin
                    g_d           = shadow_q;
                    commit_done_d = 1'b1;
                    idx_d         = '0;
                    state_d       = IDLE;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // A new frame error in the same cycle as a clear must not be lost.
    always_comb begin
        err_d = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    assign g_o           = g_q;
    assign busy_o        = (state_q != IDLE);
    assign commit_done_o = commit_done_q;
    assign err_o         = err_q;
endmodule

// File: tb/tb_eq_gain_loader.sv
// Frame-level bench for eq_gain_loader: table of frames plus hand-built corner sequences,
// committed gain sets checked by a queue-based scoreboard on every commit_done pulse.
module tb_eq_gain_loader;
    localparam int NB = 8;
    localparam int GW = 16;
    localparam logic [GW-1:0] DEF = 16'h4000;

    typedef logic [NB-1:0][GW-1:0] gains_t;

    typedef struct packed {
        logic [3:0]           nw;
        logic [9:0][GW-1:0]   w;
        logic                 exp_commit;
        logic                 exp_err;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   sample_strobe = 1'b0;
    logic   err_clr = 1'b0;
    gains_t g;
    logic   busy, commit_done, err;

    eq_gain_loader_if #(.GW(GW)) cfg_if ();

    eq_gain_loader #(
        .NBANDS(NB), .GW(GW), .DEFAULT_GAIN(16'h4000), .GMAX(16'h7FFF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg             (cfg_if),
        .sample_strobe_i (sample_strobe),
        .err_clr_i       (err_clr),
        .g_o             (g),
        .busy_o          (busy),
        .commit_done_o   (commit_done),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    int     n_tests = 0;
    int     n_fail = 0;
    int     n_commits = 0;
    gains_t exp_q[$];
    gains_t model_g;
    gains_t mon_e;
    vec_t   vecs[7];

    task automatic check(string name, logic [NB*GW-1:0] act, logic [NB*GW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [GW-1:0] clamp(logic [GW-1:0] w);
        return (w > 16'h7FFF) ? 16'h7FFF : w;
    endfunction

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(logic [GW-1:0] d, logic last, logic strobe = 1'b0, logic clr = 1'b0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_data  = d;
        cfg_if.cfg_last  = last;
        sample_strobe    = strobe;
        err_clr          = clr;
        tick();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_last  = 1'b0;
        sample_strobe    = 1'b0;
        err_clr          = 1'b0;
    endtask

    task automatic strobe_pulse();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    // Scoreboard: every commit_done pulse must match the oldest expected gain set.
    always @(negedge clk) begin
        if (!rst && commit_done === 1'b1) begin
            n_commits++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_commit: got g=%h with commit_done=1, expected no commit", g);
            end else begin
                mon_e = exp_q.pop_front();
                check("scoreboard_g", g, mon_e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        gains_t e;
        int     c0;

        for (int k = 0; k < NB; k++) model_g[k] = DEF;

        vecs[0].nw = 4'd8;  vecs[0].exp_commit = 1'b1; vecs[0].exp_err = 1'b0;
        vecs[1].nw = 4'd8;  vecs[1].exp_commit = 1'b1; vecs[1].exp_err = 1'b0;
        vecs[2].nw = 4'd5;  vecs[2].exp_commit = 1'b0; vecs[2].exp_err = 1'b1;
        vecs[3].nw = 4'd10; vecs[3].exp_commit = 1'b0; vecs[3].exp_err = 1'b1;
        vecs[4].nw = 4'd8;  vecs[4].exp_commit = 1'b1; vecs[4].exp_err = 1'b0;
        vecs[5].nw = 4'd1;  vecs[5].exp_commit = 1'b0; vecs[5].exp_err = 1'b1;
        vecs[6].nw = 4'd8;  vecs[6].exp_commit = 1'b1; vecs[6].exp_err = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vecs[0].w[i] = GW'(16'h1000 + i);
            vecs[1].w[i] = GW'(16'h2000 + i * 16'h0111);
            vecs[2].w[i] = GW'(16'h5000 + i);
            vecs[3].w[i] = GW'(16'h6000 + i);
            vecs[4].w[i] = GW'(16'h0001 + i * 3);
            vecs[5].w[i] = GW'(16'h7000 + i);
            vecs[6].w[i] = GW'(16'h1357 * (i + 1));
        end
        vecs[1].w[3] = 16'hFFFF;
        vecs[1].w[5] = 16'h8000;
        vecs[1].w[6] = 16'h7FFF;
        vecs[1].w[7] = 16'h8001;

        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = '0;
        cfg_if.cfg_last  = 1'b0;

        // Reset values
        rst = 1'b1;
        tick();
        check("ready_in_reset", cfg_if.cfg_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_reset", cfg_if.cfg_ready, 1'b1);
        check("g_reset", g, model_g);
        check("err_reset", err, 1'b0);
        check("busy_reset", busy, 1'b0);
        check("commit_done_reset", commit_done, 1'b0);

        for (int v = 0; v < 7; v++) begin
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check("err_cleared", err, 1'b0);
            for (int i = 0; i < int'(vecs[v].nw); i++) begin
                send(vecs[v].w[i], i == int'(vecs[v].nw) - 1);
                if (i == 7 && vecs[v].nw > 8) check("long_err_after_w8", err, 1'b1);
            end
            check("frame_err", err, vecs[v].exp_err);
            check("busy_after_frame", busy, vecs[v].exp_commit);
            check("g_held_before_strobe", g, model_g);
            tick(2);
            if (vecs[v].exp_commit) begin
                for (int k = 0; k < NB; k++) e[k] = clamp(vecs[v].w[k]);
                exp_q.push_back(e);
                model_g = e;
            end
            c0 = n_commits;
            strobe_pulse();
            check("commit_done_after_strobe", commit_done, vecs[v].exp_commit);
            check("g_after_strobe", g, model_g);
            if (v == 1) begin
                check("clamp_g3", g[3], 16'h7FFF);
                check("clamp_g5", g[5], 16'h7FFF);
            end
            tick();
            check("commit_done_one_cycle", commit_done, 1'b0);
            check("busy_after_commit", busy, 1'b0);
            tick();
            check("commit_count", n_commits - c0, int'(vecs[v].exp_commit));
        end

        // err set and err_clr in the same cycle: set wins
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b1, 1'b0, 1'b1);
        check("err_set_beats_clr", err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr_alone", err, 1'b0);

        // Valid gap mid-frame, strobe with word 7, then earliest commit
        for (int i = 0; i < 4; i++) send(GW'(16'h0A00 + i), 1'b0);
        tick(2);
        check("busy_during_gap", busy, 1'b1);
        for (int i = 4; i < 7; i++) send(GW'(16'h0A00 + i), 1'b0);
        send(16'h0A07, 1'b1, 1'b1);
        check("no_commit_with_word7", commit_done, 1'b0);
        check("pend_busy", busy, 1'b1);
        check("pend_not_ready", cfg_if.cfg_ready, 1'b0);
        check("g_held_in_pend", g, model_g);
        for (int k = 0; k < NB; k++) e[k] = GW'(16'h0A00 + k);
        exp_q.push_back(e);
        model_g = e;
        strobe_pulse();
        check("earliest_commit_done", commit_done, 1'b1);
        check("earliest_commit_g", g, model_g);
        tick();
        check("earliest_commit_one_cycle", commit_done, 1'b0);

        // Reset while a frame is pending
        for (int i = 0; i < 8; i++) send(GW'(16'h3000 + i), i == 7);
        check("pend_before_reset", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("ready_low_in_rst", cfg_if.cfg_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        for (int k = 0; k < NB; k++) model_g[k] = DEF;
        check("g_after_pend_reset", g, model_g);
        check("busy_after_pend_reset", busy, 1'b0);
        check("ready_after_pend_reset", cfg_if.cfg_ready, 1'b1);
        strobe_pulse();
        check("no_commit_after_reset", commit_done, 1'b0);
        check("g_default_after_strobe", g, model_g);

        tick(2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
